axi_lite_timer: RTL
===================

AXI_LITE_TIMER -- requirements
Module: axi_lite_timer

Interface
REQ-001 SHALL have parameter AXI_ADDR_BW_p, default 32: AXI address width.
REQ-002 SHALL have parameter AXI_DATA_BW_p, default 32: AXI data width; only 32 is supported.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port awaddr_i, input, AXI_ADDR_BW_p: write address.
REQ-006 SHALL have ports awvalid_i (input, 1) and awready_o (output, 1): AW handshake.
REQ-007 SHALL have port wdata_i, input, 32: write data.
REQ-008 SHALL have port wstrb_i, input, 4: byte-lane write enables.
REQ-009 SHALL have ports wvalid_i (input, 1) and wready_o (output, 1): W handshake.
REQ-010 SHALL have ports bresp_o (output, 2), bvalid_o (output, 1) and bready_i (input, 1): write response.
REQ-011 SHALL have port araddr_i, input, AXI_ADDR_BW_p: read address.
REQ-012 SHALL have ports arvalid_i (input, 1) and arready_o (output, 1): AR handshake.
REQ-013 SHALL have ports rdata_o (output, 32), rresp_o (output, 2), rvalid_o (output, 1) and rready_i (input, 1): read data channel.
REQ-014 SHALL have port irq_o, output, 1: registered timer interrupt, level.

Function
REQ-015 Register map, decoded on addr[11:0]; addr[1:0] ignored:
- 0x00 CTRL (bit0 EN, bit1 IRQ_EN, bit2 AUTO_RELOAD; other bits read 0)
- 0x04 STATUS (bit0 MATCH, write-1-to-clear)
- 0x08 COUNT
- 0x0C COMPARE
- 0x10 PRESCALE
REQ-016 Any other offset SHALL return SLVERR (2'b10), read data 0 and no register change; valid offsets SHALL return OKAY (2'b00).
REQ-017 AW and W SHALL be accepted independently; each is held in a one-entry buffer with its ready low while full.
REQ-018 The register write SHALL occur in the cycle after both buffers are full; bvalid_o SHALL rise in that same cycle.
REQ-019 bvalid_o SHALL hold until bready_i; both buffers SHALL free on the B handshake; at most one write is outstanding.
REQ-020 Writes SHALL honour wstrb_i per byte; wstrb_i = 0 SHALL give OKAY with no change.
REQ-021 arready_o SHALL be high whenever rvalid_o is low.
REQ-022 An AR handshake SHALL drive rvalid_o high the next cycle with rdata_o/rresp_o registered; these SHALL hold stable until rready_i.
REQ-023 Reads and writes SHALL proceed concurrently; a read in the same cycle as a write to the same register SHALL return the old value.
REQ-024 Prescaler: with EN=1, an internal 32-bit prescale counter SHALL count 0..PRESCALE; each wrap back to 0 is a tick that increments COUNT.
REQ-025 PRESCALE=0 SHALL tick every cycle.
REQ-026 With EN=0, the prescale counter SHALL hold at 0 and COUNT SHALL hold its value.
REQ-027 On a tick with COUNT==COMPARE, MATCH SHALL set and COUNT SHALL become 0 if AUTO_RELOAD=1, else COUNT+1.
REQ-028 COUNT SHALL wrap from 0xFFFF_FFFF to 0 without setting MATCH unless COMPARE matches.
REQ-029 A software write to COUNT SHALL take priority over a same-cycle tick and SHALL reset the prescale counter.
REQ-030 A same-cycle hardware MATCH set and W1C clear SHALL leave MATCH=1.
REQ-031 irq_o SHALL be registered MATCH & IRQ_EN, i.e. one cycle after MATCH/IRQ_EN change.

Reset
REQ-032 rst_i high at a clock edge SHALL clear all registers, counters and buffers, and drive all *ready_o, bvalid_o, rvalid_o, irq_o, rdata_o, bresp_o and rresp_o to 0.
REQ-033 Reset mid-transaction SHALL abort it with no response issued afterwards.
REQ-034 After rst_i falls, awready_o, wready_o and arready_o SHALL be 1 on the first cycle.

Verification
REQ-035 W presented 3 cycles before AW to 0x0C, data 0x10, strb 0xF -> one B OKAY; COMPARE reads 0x10.
REQ-036 PRESCALE=2, COMPARE=3, CTRL=0x7 -> COUNT increments every 3 cycles; MATCH sets on the 4th tick with COUNT 3->0; irq_o high one cycle later.
REQ-037 CTRL=0x1 (no reload), COUNT written 0xFFFF_FFFF, COMPARE=5 -> COUNT wraps to 0 on the next tick with MATCH=0.
REQ-038 Read of 0x20 -> rresp 2'b10, rdata 0; write to 0x14 -> bresp 2'b10 and no register change.
REQ-039 rready_i held low 5 cycles -> rdata_o stable and arready_o low throughout; write to STATUS 0x1 in the MATCH-set cycle -> MATCH remains 1.

Source files
------------

// File: rtl/axi_lite_timer.sv
// axi_lite_timer: AXI4-Lite register slave around a prescaled 32-bit up-counter
// with compare match, optional auto-reload and a registered level interrupt.
module axi_lite_timer #(
    parameter int AXI_ADDR_BW_p = 32,
    parameter int AXI_DATA_BW_p = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [AXI_ADDR_BW_p-1:0]   awaddr_i,
    input  logic                       awvalid_i,
    output logic                       awready_o,
    input  logic [AXI_DATA_BW_p-1:0]   wdata_i,
    input  logic [AXI_DATA_BW_p/8-1:0] wstrb_i,
    input  logic                       wvalid_i,
    output logic                       wready_o,
    output logic [1:0]                 bresp_o,
    output logic                       bvalid_o,
    input  logic                       bready_i,
    input  logic [AXI_ADDR_BW_p-1:0]   araddr_i,
    input  logic                       arvalid_i,
    output logic                       arready_o,
    output logic [AXI_DATA_BW_p-1:0]   rdata_o,
    output logic [1:0]                 rresp_o,
    output logic                       rvalid_o,
    input  logic                       rready_i,
    output logic                       irq_o
);

    localparam int          DW = AXI_DATA_BW_p;
    localparam int unsigned SW = unsigned'(AXI_DATA_BW_p / 8);

    localparam logic [9:0] OFF_CTRL     = 10'd0;
    localparam logic [9:0] OFF_STATUS   = 10'd1;
    localparam logic [9:0] OFF_COUNT    = 10'd2;
    localparam logic [9:0] OFF_COMPARE  = 10'd3;
    localparam logic [9:0] OFF_PRESCALE = 10'd4;

    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;
    localparam logic [DW-1:0] ONE         = {{(DW-1){1'b0}}, 1'b1};

    // Write-side buffers
    logic          aw_full;
    logic [9:0]    aw_off;
    logic          w_full;
    logic [DW-1:0] w_data;
    logic [SW-1:0] w_strb;

    // Register file and timer state
    logic [2:0]    ctrl;
    logic          match;
    logic [DW-1:0] count;
    logic [DW-1:0] compare;
    logic [DW-1:0] prescale;
    logic [DW-1:0] pre;

    logic          wr_fire;
    logic          wr_hit;
    logic [DW-1:0] old_val;
    logic [DW-1:0] merged;
    logic          count_load;
    logic          match_clr;
    logic          match_set;
    logic          tick;
    logic          count_hit;

    logic [9:0]    rd_off;
    logic [DW-1:0] rd_data;
    logic          rd_err;

    logic          unused_addr;

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int unsigned i = 0; i < SW; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign awready_o = ~rst_i & ~aw_full;
    assign wready_o  = ~rst_i & ~w_full;
    assign arready_o = ~rst_i & ~rvalid_o;

    assign unused_addr = ^{awaddr_i[AXI_ADDR_BW_p-1:12], awaddr_i[1:0],
                           araddr_i[AXI_ADDR_BW_p-1:12], araddr_i[1:0]};

    // Buffers stay full until the B handshake, so only one write is ever in flight.
    assign wr_fire = aw_full & w_full & ~bvalid_o;
    assign wr_hit  = (aw_off <= OFF_PRESCALE);

    always_comb begin
        old_val = '0;
        case (aw_off)
            OFF_CTRL:     old_val = {{(DW-3){1'b0}}, ctrl};
            OFF_COUNT:    old_val = count;
            OFF_COMPARE:  old_val = compare;
            OFF_PRESCALE: old_val = prescale;
            default:      old_val = '0;
        endcase
        merged = merge_bytes(old_val, w_data, w_strb);
    end

    assign count_load = wr_fire & (aw_off == OFF_COUNT) & (|w_strb);
    assign match_clr  = wr_fire & (aw_off == OFF_STATUS) & w_strb[0] & w_data[0];
    assign tick       = ctrl[0] & (pre >= prescale);
    assign count_hit  = (count == compare);
    // A software COUNT load swallows the coincident tick entirely, including its match.
    assign match_set  = tick & ~count_load & count_hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_full  <= 1'b0;
            aw_off   <= '0;
            w_full   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid_o <= 1'b0;
            bresp_o  <= RESP_OKAY;
        end else begin
            if (awvalid_i && awready_o) begin
                aw_full <= 1'b1;
                aw_off  <= awaddr_i[11:2];
            end
            if (wvalid_i && wready_o) begin
                w_full <= 1'b1;
                w_data <= wdata_i;
                w_strb <= wstrb_i;
            end
            if (wr_fire) begin
                bvalid_o <= 1'b1;
                bresp_o  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_o && bready_i) begin
                bvalid_o <= 1'b0;
                aw_full  <= 1'b0;
                w_full   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl     <= '0;
            compare  <= '0;
            prescale <= '0;
        end else if (wr_fire) begin
            case (aw_off)
                OFF_CTRL:     ctrl     <= merged[2:0];
                OFF_COMPARE:  compare  <= merged;
                OFF_PRESCALE: prescale <= merged;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre   <= '0;
            count <= '0;
            match <= 1'b0;
            irq_o <= 1'b0;
        end else begin
            if (count_load) begin
                count <= merged;
                pre   <= '0;
            end else if (!ctrl[0]) begin
                pre <= '0;
            end else if (tick) begin
                pre   <= '0;
                count <= (count_hit && ctrl[2]) ? '0 : count + ONE;
            end else begin
                pre <= pre + ONE;
            end
            match <= match_set | (match & ~match_clr);
            irq_o <= match & ctrl[1];
        end
    end

    assign rd_off = araddr_i[11:2];

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (rd_off)
            OFF_CTRL:     rd_data = {{(DW-3){1'b0}}, ctrl};
            OFF_STATUS:   rd_data = {{(DW-1){1'b0}}, match};
            OFF_COUNT:    rd_data = count;
            OFF_COMPARE:  rd_data = compare;
            OFF_PRESCALE: rd_data = prescale;
            default:      rd_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            rresp_o  <= RESP_OKAY;
        end else if (arvalid_i && arready_o) begin
            rvalid_o <= 1'b1;
            rdata_o  <= rd_data;
            rresp_o  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_o && rready_i) begin
            rvalid_o <= 1'b0;
        end
    end

endmodule
